// File: rtl/fp_divide_iter.sv
// fp_divide_iter: iterative radix-2 IEEE-754 divider (one quotient bit per cycle) with normalise/round stages.
// Optional feature macro FPDIV_DENORMAL_EN: full subnormal support; when undefined subnormals flush to signed zero.
module fp_divide_iter #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] a,
    input  logic [EXP_W+FRAC_W:0] b,
    input  logic [2:0]            rm,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] o,
    output logic [4:0]            flags,
    output logic [TAG_W-1:0]      out_tag
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int MW = FRAC_W + 1;
    localparam int QW = FRAC_W + 3;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(QW + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EW-1:0]    EMAX     = {2'b00, EXP_ONES};
    localparam logic [EW-1:0]    BIAS     = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [W-1:0]     QBIT     = {{(EXP_W+1){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_PRENORM, S_DIV, S_NORM, S_ROUND, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, o_q, o_d;
    logic [2:0]       rm_q, rm_d;
    logic [TAG_W-1:0] tag_q, tag_d, out_tag_q, out_tag_d;
    logic [4:0]       flags_q, flags_d;
    logic             sign_q, sign_d, special_q, special_d, sticky_q, sticky_d, tiny_q, tiny_d;
    logic [EW-1:0]    exp_q, exp_d;
    logic [MW:0]      rem_q, rem_d;
    logic [MW-1:0]    div_q, div_d;
    logic [QW-1:0]    quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic accept;
    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid = (state_q == S_DONE);
    assign accept    = ce && in_valid && in_ready;
    assign o         = o_q;
    assign flags     = flags_q;
    assign out_tag   = out_tag_q;

    // Operand decode and special-case classification
    logic sa, sb, sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
    logic [EXP_W-1:0]  ea, eb, ea_eff, eb_eff;
    logic [FRAC_W-1:0] fa, fb;
    logic [W-1:0]      spec_res;
    logic [4:0]        spec_flags;
    assign {sa, ea, fa} = a_q;
    assign {sb, eb, fb} = b_q;
    assign sgn    = sa ^ sb;
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
`ifdef FPDIV_DENORMAL_EN
    assign a_zero = (ea == '0) && (fa == '0);
    assign b_zero = (eb == '0) && (fb == '0);
`else
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
`endif
    assign ea_eff = (ea == '0) ? EXP_W'(1) : ea;
    assign eb_eff = (eb == '0) ? EXP_W'(1) : eb;

    always_comb begin
        special    = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (a_nan) begin
            spec_res   = a_q | QBIT;
            spec_flags = {~fa[FRAC_W-1], 4'b0000};
        end else if (b_nan) begin
            spec_res   = b_q | QBIT;
            spec_flags = {~fb[FRAC_W-1], 4'b0000};
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res   = QNAN;
            spec_flags = 5'b10000;
        end else if (a_inf) begin
            spec_res   = {sgn, EXP_ONES, {FRAC_W{1'b0}}};
        end else if (b_zero) begin
            spec_res   = {sgn, EXP_ONES, {FRAC_W{1'b0}}};
            spec_flags = 5'b01000;
        end else if (b_inf || a_zero) begin
            spec_res   = {sgn, {(W-1){1'b0}}};
        end else begin
            special    = 1'b0;
        end
    end

    // Restoring divide step: remainder stays below twice the divisor
    logic          rem_ge;
    logic [MW:0]   rem_sub;
    assign rem_ge  = rem_q >= {1'b0, div_q};
    assign rem_sub = rem_ge ? rem_q - {1'b0, div_q} : rem_q;

`ifdef FPDIV_DENORMAL_EN
    function automatic logic [EW-1:0] lzc(input logic [MW-1:0] v);
        logic [EW-1:0] n;
        n = EW'(MW);
        for (int i = 0; i < MW; i++)
            if (v[i]) n = EW'(MW - 1 - i);
        return n;
    endfunction
    logic [EW-1:0] lz_a, lz_b, norm_sh;
    assign lz_a = lzc(rem_q[MW-1:0]);
    assign lz_b = lzc(div_q);
`endif

    logic [QW-1:0] norm_quo;
    logic [EW-1:0] norm_exp;
    logic          norm_stk;
    always_comb begin
        norm_quo = quo_q;
        norm_exp = exp_q;
        norm_stk = |rem_q;
        if (!quo_q[QW-1]) begin
            norm_quo = {quo_q[QW-2:0], 1'b0};
            norm_exp = exp_q - EW'(1);
        end
`ifdef FPDIV_DENORMAL_EN
        norm_sh = '0;
        if (norm_exp[EW-1] || (norm_exp == '0)) begin
            norm_sh = EW'(1) - norm_exp;
            if (norm_sh > EW'(QW)) norm_sh = EW'(QW);
            for (int i = 0; i < QW; i++)
                if (EW'(i) < norm_sh) norm_stk = norm_stk | norm_quo[i];
            norm_quo = norm_quo >> norm_sh;
            norm_exp = '0;
        end
`endif
    end

    // Rounding: {exp,frac} is incremented as one field so a mantissa carry bumps the exponent
    logic [FRAC_W-1:0] frac_r;
    logic              rnd_g, rnd_s, rnd_inc, ovf, ov_inf, nx, uf;
    logic [W-1:0]      mag_r, rnd_o;
    logic [4:0]        rnd_flags;
    assign frac_r = quo_q[QW-2:2];
    assign rnd_g  = quo_q[1];
    assign rnd_s  = quo_q[0] | sticky_q;
    assign nx     = rnd_g | rnd_s;
    assign mag_r  = {1'b0, exp_q[EXP_W-1:0], frac_r} + {{(W-1){1'b0}}, rnd_inc};
    assign ovf    = (!exp_q[EW-1] && (exp_q >= EMAX)) || mag_r[W-1] ||
                    (mag_r[FRAC_W +: EXP_W] == EXP_ONES);
`ifdef FPDIV_DENORMAL_EN
    assign uf     = (mag_r[FRAC_W +: EXP_W] == '0) && nx;
`else
    assign uf     = 1'b0;
`endif

    always_comb begin
        case (rm_q)
            3'b001:  begin rnd_inc = 1'b0;                  ov_inf = 1'b0;    end
            3'b010:  begin rnd_inc = sign_q & nx;           ov_inf = sign_q;  end
            3'b011:  begin rnd_inc = ~sign_q & nx;          ov_inf = ~sign_q; end
            3'b100:  begin rnd_inc = rnd_g;                 ov_inf = 1'b1;    end
            default: begin rnd_inc = rnd_g & (rnd_s | frac_r[0]); ov_inf = 1'b1; end
        endcase
    end

    always_comb begin
        rnd_o     = {sign_q, mag_r[W-2:0]};
        rnd_flags = {3'b000, uf, nx};
        if (ovf) begin
            rnd_o     = ov_inf ? {sign_q, EXP_ONES, {FRAC_W{1'b0}}} : {sign_q, EXP_MAXF, {FRAC_W{1'b1}}};
            rnd_flags = 5'b00101;
        end
`ifndef FPDIV_DENORMAL_EN
        if (tiny_q) begin
            rnd_o     = {sign_q, {(W-1){1'b0}}};
            rnd_flags = 5'b00011;
        end
`endif
    end

    always_comb begin
        state_d = state_q;  a_d = a_q;  b_d = b_q;  rm_d = rm_q;  tag_d = tag_q;
        o_d = o_q;  flags_d = flags_q;  out_tag_d = out_tag_q;
        sign_d = sign_q;  special_d = special_q;  sticky_d = sticky_q;  tiny_d = tiny_q;
        exp_d = exp_q;  rem_d = rem_q;  div_d = div_q;  quo_d = quo_q;  cnt_d = cnt_q;
        if (ce) begin
            case (state_q)
                S_IDLE: if (accept) state_d = S_UNPACK;
                S_UNPACK: begin
                    sign_d    = sgn;
                    exp_d     = {2'b00, ea_eff} - {2'b00, eb_eff} + BIAS;
                    rem_d     = {1'b0, (ea != '0), fa};
                    div_d     = {(eb != '0), fb};
                    cnt_d     = CW'(QW - 1);
                    special_d = special;
                    if (special) begin
                        // Specials share the ROUND hand-off so every result leaves the same way
                        o_d     = spec_res;
                        flags_d = spec_flags;
                        state_d = S_ROUND;
                    end else begin
`ifdef FPDIV_DENORMAL_EN
                        state_d = S_PRENORM;
`else
                        state_d = S_DIV;
`endif
                    end
                end
`ifdef FPDIV_DENORMAL_EN
                S_PRENORM: begin
                    rem_d   = {1'b0, rem_q[MW-1:0] << lz_a};
                    div_d   = div_q << lz_b;
                    exp_d   = exp_q - lz_a + lz_b;
                    state_d = S_DIV;
                end
`endif
                S_DIV: begin
                    rem_d = rem_sub << 1;
                    quo_d = {quo_q[QW-2:0], rem_ge};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) state_d = S_NORM;
                end
                S_NORM: begin
                    quo_d    = norm_quo;
                    exp_d    = norm_exp;
                    sticky_d = norm_stk;
                    tiny_d   = norm_exp[EW-1] || (norm_exp == '0);
                    state_d  = S_ROUND;
                end
                S_ROUND: begin
                    out_tag_d = tag_q;
                    if (!special_q) begin
                        o_d     = rnd_o;
                        flags_d = rnd_flags;
                    end
                    state_d = S_DONE;
                end
                S_DONE: if (out_ready) state_d = accept ? S_UNPACK : S_IDLE;
                default: state_d = S_IDLE;
            endcase
            if (accept) begin
                a_d   = a;
                b_d   = b;
                rm_d  = rm;
                tag_d = in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;  a_q <= '0;  b_q <= '0;  rm_q <= '0;  tag_q <= '0;
            o_q <= '0;  flags_q <= '0;  out_tag_q <= '0;
            sign_q <= 1'b0;  special_q <= 1'b0;  sticky_q <= 1'b0;  tiny_q <= 1'b0;
            exp_q <= '0;  rem_q <= '0;  div_q <= '0;  quo_q <= '0;  cnt_q <= '0;
        end else begin
            state_q <= state_d;  a_q <= a_d;  b_q <= b_d;  rm_q <= rm_d;  tag_q <= tag_d;
            o_q <= o_d;  flags_q <= flags_d;  out_tag_q <= out_tag_d;
            sign_q <= sign_d;  special_q <= special_d;  sticky_q <= sticky_d;  tiny_q <= tiny_d;
            exp_q <= exp_d;  rem_q <= rem_d;  div_q <= div_d;  quo_q <= quo_d;  cnt_q <= cnt_d;
        end
    end
endmodule
